// File: rtl/vp_validation_queue.sv
// vp_validation_queue
// Program-order buffer between the value predictor's prediction port and its
// feedback port. Each queued prediction is matched against the executed result
// and a registered feedback record is produced one cycle after retirement.
// Optional statistics counters are built only when VP_VQ_STATS_EN is defined;
// otherwise the stat ports are tied to zero.
//
// Handshake: pred_valid_i / exe_valid_i are fire-and-forget requests with no
// ready. A prediction lane that finds no free slot is dropped (overflow_o).
// An exe lane with no queued entry is dropped (underflow_o). Lanes on both
// sides must be packed toward lane 0.
module vp_validation_queue #(
  parameter int P_DEPTH    = 16,
  parameter int P_NUM_PRED = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [P_NUM_PRED-1:0][31:0]  pred_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]  pred_result_i,
  input  logic [P_NUM_PRED-1:0]        pred_conf_i,
  input  logic [P_NUM_PRED-1:0]        pred_valid_i,
  input  logic [P_NUM_PRED-1:0][31:0]  exe_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]  exe_actual_i,
  input  logic [P_NUM_PRED-1:0]        exe_valid_i,
  output logic [P_NUM_PRED-1:0][31:0]  fb_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]  fb_actual_o,
  output logic [P_NUM_PRED-1:0]        fb_mispredict_o,
  output logic [P_NUM_PRED-1:0]        fb_conf_o,
  output logic [P_NUM_PRED-1:0]        fb_valid_o,
  output logic [$clog2(P_DEPTH):0]     count_o,
  output logic                         overflow_o,
  output logic                         underflow_o,
  output logic                         pc_mismatch_o,
  output logic [31:0]                  stat_retired_o,
  output logic [31:0]                  stat_mispred_o,
  output logic [31:0]                  stat_conf_hit_o
);

  localparam int PW = $clog2(P_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(P_DEPTH);

  // Entry storage (no reset; contents only meaningful between the pointers)
  logic [31:0] mem_pc   [P_DEPTH];
  logic [31:0] mem_val  [P_DEPTH];
  logic        mem_conf [P_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [P_NUM_PRED-1:0][31:0] fb_pc_q, fb_pc_d;
  logic [P_NUM_PRED-1:0][31:0] fb_actual_q, fb_actual_d;
  logic [P_NUM_PRED-1:0]       fb_mispredict_q, fb_mispredict_d;
  logic [P_NUM_PRED-1:0]       fb_conf_q, fb_conf_d;
  logic [P_NUM_PRED-1:0]       fb_valid_q, fb_valid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic pc_mismatch_q, pc_mismatch_d;

  logic [P_NUM_PRED-1:0]         wr_en;
  logic [P_NUM_PRED-1:0][PW-1:0] wr_idx;
  logic [P_NUM_PRED-1:0][PW-1:0] rd_idx;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] acc_cnt;
  logic [CW-1:0] pop_cnt;
  logic pred_lanes_ok;
  logic exe_lanes_ok;

  // Enqueue: lanes claim free slots in order; space is judged at cycle start
  always_comb begin
    free_slots = DEPTH_C - count_q;
    acc_cnt    = '0;
    wr_en      = '0;
    wr_idx     = '0;
    overflow_d = 1'b0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      wr_idx[k] = wr_ptr_q + PW'(k);
      if (pred_valid_i[k] && !flush_i) begin
        if (CW'(k) < free_slots) begin
          wr_en[k] = 1'b1;
          acc_cnt  = acc_cnt + CW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // Dequeue: lane k retires the k-th oldest entry and builds its feedback
  always_comb begin
    pop_cnt         = '0;
    rd_idx          = '0;
    fb_valid_d      = '0;
    fb_pc_d         = '0;
    fb_actual_d     = '0;
    fb_mispredict_d = '0;
    fb_conf_d       = '0;
    underflow_d     = 1'b0;
    pc_mismatch_d   = 1'b0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      rd_idx[k] = rd_ptr_q + PW'(k);
      if (exe_valid_i[k] && !flush_i) begin
        if (CW'(k) < count_q) begin
          pop_cnt = pop_cnt + CW'(1);
          if (mem_pc[rd_idx[k]] == exe_pc_i[k]) begin
            fb_valid_d[k]      = 1'b1;
            fb_pc_d[k]         = mem_pc[rd_idx[k]];
            fb_actual_d[k]     = exe_actual_i[k];
            fb_mispredict_d[k] = (mem_val[rd_idx[k]] != exe_actual_i[k]);
            fb_conf_d[k]       = mem_conf[rd_idx[k]];
          end else begin
            pc_mismatch_d = 1'b1;
          end
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  // Pointer and occupancy update; flush empties the queue outright
  always_comb begin
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + acc_cnt[PW-1:0];
      rd_ptr_d = rd_ptr_q + pop_cnt[PW-1:0];
      count_d  = count_q + acc_cnt - pop_cnt;
    end
  end

  // Lane packing legality (lane k may only be valid if lane k-1 is)
  always_comb begin
    pred_lanes_ok = 1'b1;
    exe_lanes_ok  = 1'b1;
    for (int k = 1; k < P_NUM_PRED; k++) begin
      if (pred_valid_i[k] && !pred_valid_i[k-1]) pred_lanes_ok = 1'b0;
      if (exe_valid_i[k] && !exe_valid_i[k-1])   exe_lanes_ok  = 1'b0;
    end
  end

  a_pred_packed: assert property (@(posedge clk_i) disable iff (rst_i) pred_lanes_ok);
  a_exe_packed:  assert property (@(posedge clk_i) disable iff (rst_i) exe_lanes_ok);

  // Entry storage writes for accepted lanes
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < P_NUM_PRED; k++) begin
      if (wr_en[k]) begin
        mem_pc[wr_idx[k]]   <= pred_pc_i[k];
        mem_val[wr_idx[k]]  <= pred_result_i[k];
        mem_conf[wr_idx[k]] <= pred_conf_i[k];
      end
    end
  end

  // Control state, feedback and pulse registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      fb_pc_q         <= '0;
      fb_actual_q     <= '0;
      fb_mispredict_q <= '0;
      fb_conf_q       <= '0;
      fb_valid_q      <= '0;
      overflow_q      <= 1'b0;
      underflow_q     <= 1'b0;
      pc_mismatch_q   <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      fb_pc_q         <= fb_pc_d;
      fb_actual_q     <= fb_actual_d;
      fb_mispredict_q <= fb_mispredict_d;
      fb_conf_q       <= fb_conf_d;
      fb_valid_q      <= fb_valid_d;
      overflow_q      <= overflow_d;
      underflow_q     <= underflow_d;
      pc_mismatch_q   <= pc_mismatch_d;
    end
  end

  assign fb_pc_o         = fb_pc_q;
  assign fb_actual_o     = fb_actual_q;
  assign fb_mispredict_o = fb_mispredict_q;
  assign fb_conf_o       = fb_conf_q;
  assign fb_valid_o      = fb_valid_q;
  assign count_o         = count_q;
  assign overflow_o      = overflow_q;
  assign underflow_o     = underflow_q;
  assign pc_mismatch_o   = pc_mismatch_q;

`ifdef VP_VQ_STATS_EN
  logic [31:0] stat_ret_q, stat_ret_d;
  logic [31:0] stat_mis_q, stat_mis_d;
  logic [31:0] stat_hit_q, stat_hit_d;
  logic [31:0] inc_ret, inc_mis, inc_hit;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Statistics follow the registered feedback outputs; saturate at all-ones
  always_comb begin
    inc_ret = '0;
    inc_mis = '0;
    inc_hit = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      if (fb_valid_q[k]) begin
        inc_ret = inc_ret + 32'd1;
        if (fb_mispredict_q[k]) inc_mis = inc_mis + 32'd1;
        else if (fb_conf_q[k])  inc_hit = inc_hit + 32'd1;
      end
    end
    stat_ret_d = sat_add(stat_ret_q, inc_ret);
    stat_mis_d = sat_add(stat_mis_q, inc_mis);
    stat_hit_d = sat_add(stat_hit_q, inc_hit);
  end

  // Statistics registers: cleared by reset only, never by flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_ret_q <= '0;
      stat_mis_q <= '0;
      stat_hit_q <= '0;
    end else begin
      stat_ret_q <= stat_ret_d;
      stat_mis_q <= stat_mis_d;
      stat_hit_q <= stat_hit_d;
    end
  end

  assign stat_retired_o  = stat_ret_q;
  assign stat_mispred_o  = stat_mis_q;
  assign stat_conf_hit_o = stat_hit_q;
`else
  assign stat_retired_o  = 32'd0;
  assign stat_mispred_o  = 32'd0;
  assign stat_conf_hit_o = 32'd0;
`endif

endmodule

// File: tb/tb_vp_validation_queue.sv
// Directed bench for vp_validation_queue (P_DEPTH=16, P_NUM_PRED=2).
// Each step drives one cycle of inputs, pushes the expected output record for
// the following cycle, and the record is popped and compared at the next
// falling edge. Stat expectations are accumulated from the expected feedback.
module tb_vp_validation_queue;

  localparam int DEPTH = 16;
  localparam int NP    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              flush;
  logic [1:0][31:0]  pred_pc, pred_res, exe_pc, exe_act, fb_pc, fb_act;
  logic [1:0]        pred_conf, pred_valid, exe_valid;
  logic [1:0]        fb_mp, fb_conf, fb_valid;
  logic [4:0]        count;
  logic              ovf, udf, pcm;
  logic [31:0]       st_ret, st_mis, st_hit;

  vp_validation_queue #(.P_DEPTH(DEPTH), .P_NUM_PRED(NP)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .pred_pc_i(pred_pc), .pred_result_i(pred_res), .pred_conf_i(pred_conf),
    .pred_valid_i(pred_valid),
    .exe_pc_i(exe_pc), .exe_actual_i(exe_act), .exe_valid_i(exe_valid),
    .fb_pc_o(fb_pc), .fb_actual_o(fb_act), .fb_mispredict_o(fb_mp),
    .fb_conf_o(fb_conf), .fb_valid_o(fb_valid),
    .count_o(count), .overflow_o(ovf), .underflow_o(udf), .pc_mismatch_o(pcm),
    .stat_retired_o(st_ret), .stat_mispred_o(st_mis), .stat_conf_hit_o(st_hit)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]       v;
    logic [1:0]       mp;
    logic [1:0]       cf;
    logic [1:0][31:0] pc;
    logic [1:0][31:0] act;
    logic             ovf;
    logic             udf;
    logic             pcm;
    logic [4:0]       cnt;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val;
    logic        conf;
  } ent_t;

  exp_t exp_q[$];
  ent_t model_q[$];
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_ret = 0, exp_mis = 0, exp_hit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [1:0] v, input logic [1:0] mp, input logic [1:0] cf,
                          input logic [31:0] pc1, input logic [31:0] pc0,
                          input logic [31:0] a1, input logic [31:0] a0,
                          input logic o, input logic u, input logic p, input logic [4:0] cnt);
    exp_t e;
    e.v = v; e.mp = mp; e.cf = cf;
    e.pc[1] = pc1; e.pc[0] = pc0; e.act[1] = a1; e.act[0] = a0;
    e.ovf = o; e.udf = u; e.pcm = p; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic exp_idle(input logic [4:0] cnt);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, cnt);
  endtask

  task automatic check_out();
    exp_t e;
    chk("sb_has_entry", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("stat_retired", st_ret, exp_ret);
    chk("stat_mispred", st_mis, exp_mis);
    chk("stat_conf_hit", st_hit, exp_hit);
    chk("fb_valid", 32'(fb_valid), 32'(e.v));
    for (int k = 0; k < NP; k++) begin
      if (e.v[k]) begin
        chk($sformatf("fb_pc%0d", k), fb_pc[k], e.pc[k]);
        chk($sformatf("fb_actual%0d", k), fb_act[k], e.act[k]);
        chk($sformatf("fb_mispredict%0d", k), 32'(fb_mp[k]), 32'(e.mp[k]));
        chk($sformatf("fb_conf%0d", k), 32'(fb_conf[k]), 32'(e.cf[k]));
      end
    end
    chk("overflow", 32'(ovf), 32'(e.ovf));
    chk("underflow", 32'(udf), 32'(e.udf));
    chk("pc_mismatch", 32'(pcm), 32'(e.pcm));
    chk("count", 32'(count), 32'(e.cnt));
`ifdef VP_VQ_STATS_EN
    for (int k = 0; k < NP; k++) begin
      if (e.v[k]) begin
        exp_ret = exp_ret + 1;
        if (e.mp[k]) exp_mis = exp_mis + 1;
        else if (e.cf[k]) exp_hit = exp_hit + 1;
      end
    end
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    flush = 1'b0;
    pred_pc = '0; pred_res = '0; pred_conf = '0; pred_valid = '0;
    exe_pc = '0; exe_act = '0; exe_valid = '0;
  endtask

  task automatic enq(input int k, input logic [31:0] pc, input logic [31:0] val, input logic conf);
    pred_valid[k] = 1'b1; pred_pc[k] = pc; pred_res[k] = val; pred_conf[k] = conf;
  endtask

  task automatic exe(input int k, input logic [31:0] pc, input logic [31:0] act);
    exe_valid[k] = 1'b1; exe_pc[k] = pc; exe_act[k] = act;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_out();
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_fb_valid"}, 32'(fb_valid), 32'd0);
    chk({tag, "_fb_pc0"}, fb_pc[0], 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_pulses"}, {29'd0, ovf, udf, pcm}, 32'd0);
    chk({tag, "_stats"}, st_ret | st_mis | st_hit, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ent_t e0, e1;
    logic [31:0] a0, a1;
    idle();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // single-lane predict then correct retire
    enq(0, 32'h100, 32'h5, 1'b1);
    exp_idle(5'd1); tick();
    exe(0, 32'h100, 32'h5);
    push_exp(2'b01, 2'b00, 2'b01, 0, 32'h100, 0, 32'h5, 1'b0, 1'b0, 1'b0, 5'd0); tick();

    // two-lane predict, two-lane retire with lane 1 mispredicted
    enq(0, 32'h200, 32'h1, 1'b0); enq(1, 32'h204, 32'h2, 1'b1);
    exp_idle(5'd2); tick();
    exe(0, 32'h200, 32'h1); exe(1, 32'h204, 32'h9);
    push_exp(2'b11, 2'b10, 2'b10, 32'h204, 32'h200, 32'h9, 32'h1, 1'b0, 1'b0, 1'b0, 5'd0); tick();

    // fill to full with random values
    for (int i = 0; i < 8; i++) begin
      ent_t n0, n1;
      n0.pc = 32'h1000 + 32'(8 * i); n0.val = $urandom_range(0, 255); n0.conf = 1'($urandom_range(0, 1));
      n1.pc = n0.pc + 32'h4;         n1.val = $urandom_range(0, 255); n1.conf = 1'($urandom_range(0, 1));
      enq(0, n0.pc, n0.val, n0.conf); enq(1, n1.pc, n1.val, n1.conf);
      model_q.push_back(n0); model_q.push_back(n1);
      exp_idle(5'(2 * (i + 1))); tick();
    end

    // full: both lanes dropped, overflow pulses for exactly one cycle
    enq(0, 32'h1F00, 32'h0, 1'b0); enq(1, 32'h1F04, 32'h0, 1'b0);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 5'd16); tick();
    exp_idle(5'd16); tick();

    // retire one, then 15 entries + two-lane enqueue: lane 0 in, lane 1 dropped
    e0 = model_q.pop_front();
    a0 = ($urandom_range(0, 1) == 1) ? e0.val : (e0.val ^ 32'h1);
    exe(0, e0.pc, a0);
    push_exp(2'b01, {1'b0, a0 != e0.val}, {1'b0, e0.conf}, 0, e0.pc, 0, a0, 1'b0, 1'b0, 1'b0, 5'd15); tick();
    enq(0, 32'h2000, 32'h77, 1'b1); enq(1, 32'h2004, 32'h88, 1'b1);
    e0.pc = 32'h2000; e0.val = 32'h77; e0.conf = 1'b1; model_q.push_back(e0);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 5'd16); tick();

    // drain everything in order, random hit/miss per lane
    for (int i = 0; i < 8; i++) begin
      e0 = model_q.pop_front(); e1 = model_q.pop_front();
      a0 = ($urandom_range(0, 1) == 1) ? e0.val : (e0.val ^ 32'h1);
      a1 = ($urandom_range(0, 1) == 1) ? e1.val : (e1.val ^ 32'h2);
      exe(0, e0.pc, a0); exe(1, e1.pc, a1);
      push_exp(2'b11, {a1 != e1.val, a0 != e0.val}, {e1.conf, e0.conf},
               e1.pc, e0.pc, a1, a0, 1'b0, 1'b0, 1'b0, 5'(14 - 2 * i));
      tick();
    end

    // underflow: empty queue, then one entry against two exe lanes
    exe(0, 32'h400, 32'h7);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 5'd0); tick();
    enq(0, 32'h400, 32'h7, 1'b0);
    exp_idle(5'd1); tick();
    exe(0, 32'h400, 32'h7); exe(1, 32'h404, 32'h7);
    push_exp(2'b01, 2'b00, 2'b00, 0, 32'h400, 0, 32'h7, 1'b0, 1'b1, 1'b0, 5'd0); tick();

    // pc mismatch pops the head; next entry retires normally
    enq(0, 32'h300, 32'h3, 1'b1); enq(1, 32'h308, 32'h4, 1'b1);
    exp_idle(5'd2); tick();
    exe(0, 32'h304, 32'h3);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 5'd1); tick();
    exe(0, 32'h308, 32'h4);
    push_exp(2'b01, 2'b00, 2'b01, 0, 32'h308, 0, 32'h4, 1'b0, 1'b0, 1'b0, 5'd0); tick();

    // flush with 5 entries, concurrent enqueue and a mismatching exe
    enq(0, 32'h3000, 32'h1, 1'b1); enq(1, 32'h3004, 32'h1, 1'b1); exp_idle(5'd2); tick();
    enq(0, 32'h3008, 32'h1, 1'b1); enq(1, 32'h300C, 32'h1, 1'b1); exp_idle(5'd4); tick();
    enq(0, 32'h3010, 32'h1, 1'b1); exp_idle(5'd5); tick();
    flush = 1'b1;
    enq(0, 32'h3014, 32'h1, 1'b1); enq(1, 32'h3018, 32'h1, 1'b1);
    exe(0, 32'hDEAD, 32'h1);
    exp_idle(5'd0); tick();
    exp_idle(5'd0); tick();
    // entry that would have been the head after flush must not match
    exe(0, 32'h3000, 32'h1);
    push_exp(2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 5'd0); tick();

    // asynchronous reset while feedback is valid
    enq(0, 32'h500, 32'h1, 1'b1); enq(1, 32'h504, 32'h2, 1'b1); exp_idle(5'd2); tick();
    enq(0, 32'h508, 32'h3, 1'b1); exp_idle(5'd3); tick();
    exe(0, 32'h500, 32'h1);
    push_exp(2'b01, 2'b00, 2'b01, 0, 32'h500, 0, 32'h1, 1'b0, 1'b0, 1'b0, 5'd2); tick();
    #1 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    exp_ret = 0; exp_mis = 0; exp_hit = 0;
    @(negedge clk);
    rst = 1'b0;

    // three correct confident retirements feed the statistics
    enq(0, 32'h600, 32'hA, 1'b1); enq(1, 32'h604, 32'hB, 1'b1); exp_idle(5'd2); tick();
    enq(0, 32'h608, 32'hC, 1'b1); exp_idle(5'd3); tick();
    exe(0, 32'h600, 32'hA); exe(1, 32'h604, 32'hB);
    push_exp(2'b11, 2'b00, 2'b11, 32'h604, 32'h600, 32'hB, 32'hA, 1'b0, 1'b0, 1'b0, 5'd1); tick();
    exe(0, 32'h608, 32'hC);
    push_exp(2'b01, 2'b00, 2'b01, 0, 32'h608, 0, 32'hC, 1'b0, 1'b0, 1'b0, 5'd0); tick();
    exp_idle(5'd0); tick();
    exp_idle(5'd0); tick();

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
